// File: rtl/sc_speed_tick_gen_pkg.sv
// Shared definitions for the speed tick generator: FSM encoding and the
// level-dependent period threshold.
package sc_speed_tick_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_WRAP  = 2'd2,
    ST_PAUSE = 2'd3
  } state_e;

  // Period threshold for a given speed level: base halved per level, never 0
  // so the compare always has something to reach.
  function automatic logic [31:0] thresh(input logic [31:0] base,
                                         input logic [31:0] level);
    logic [31:0] shifted;
    shifted = base >> level;
    return (shifted == 32'd0) ? 32'd1 : shifted;
  endfunction

endpackage

// File: rtl/sc_press_detect.sv
// Falling-edge (press) detector for an active-low, already debounced button.
module sc_press_detect (
  input  logic gclk,
  input  logic grst_n,
  input  logic btn_n,
  output logic press
);

  logic prev_q, prev_d;

  // Remember last cycle's button level.
  always_comb prev_d = btn_n;

  // Previous-level register; idles high (released).
  always_ff @(posedge gclk) begin
    if (!grst_n) prev_q <= 1'b1;
    else         prev_q <= prev_d;
  end

  assign press = prev_q & ~btn_n;

endmodule

// File: rtl/sc_speed_tick_gen.sv
// Speed tick generator: runs the external up-counter, compares it against a
// level-dependent threshold, and emits one-cycle tick/clear pulses per period.
// The speed level is nudged by accel/brake presses while running.
module sc_speed_tick_gen
  import sc_speed_tick_gen_pkg::*;
#(
  parameter int DATAWIDTH   = 23,
  parameter int LEVELWIDTH  = 3,
  parameter int MAX_LEVEL   = 7,
  parameter int BASE_THRESH = 4_000_000
) (
  input  logic                  SC_SPEEDTICK_CLOCK_50,
  input  logic                  SC_SPEEDTICK_RESET_InLow,
  input  logic [DATAWIDTH-1:0]  SC_SPEEDTICK_count_InBUS,
  input  logic                  SC_SPEEDTICK_start_InLow,
  input  logic                  SC_SPEEDTICK_pause_InHigh,
  input  logic                  SC_SPEEDTICK_accel_InLow,
  input  logic                  SC_SPEEDTICK_brake_InLow,
  output logic                  SC_SPEEDTICK_upcount_OutLow,
  output logic                  SC_SPEEDTICK_clear_OutHigh,
  output logic                  SC_SPEEDTICK_tick_OutHigh,
  output logic [LEVELWIDTH-1:0] SC_SPEEDTICK_level_OutBUS
);

  logic gclk, grst_n;
  assign gclk   = SC_SPEEDTICK_CLOCK_50;
  assign grst_n = SC_SPEEDTICK_RESET_InLow;

  state_e                state_q, state_d;
  logic [LEVELWIDTH-1:0] level_q, level_d;
  logic                  upcount_q, upcount_d;
  logic                  tick_q, tick_d;
  logic                  clear_q, clear_d;
  logic [DATAWIDTH-1:0]  thr;
  logic                  accel_press, brake_press;
  logic                  running;

  sc_press_detect u_accel (
    .gclk   (gclk),
    .grst_n (grst_n),
    .btn_n  (SC_SPEEDTICK_accel_InLow),
    .press  (accel_press)
  );

  sc_press_detect u_brake (
    .gclk   (gclk),
    .grst_n (grst_n),
    .btn_n  (SC_SPEEDTICK_brake_InLow),
    .press  (brake_press)
  );

  assign thr     = DATAWIDTH'(thresh(32'(BASE_THRESH), 32'(level_q)));
  assign running = (state_q == ST_RUN) || (state_q == ST_WRAP);

  // Next state; pause outranks the threshold compare in RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!SC_SPEEDTICK_start_InLow) state_d = ST_RUN;
      ST_RUN: begin
        if (SC_SPEEDTICK_pause_InHigh)           state_d = ST_PAUSE;
        else if (SC_SPEEDTICK_count_InBUS >= thr) state_d = ST_WRAP;
      end
      ST_WRAP:  state_d = SC_SPEEDTICK_pause_InHigh ? ST_PAUSE : ST_RUN;
      ST_PAUSE: if (!SC_SPEEDTICK_pause_InHigh)  state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Saturating level update; a simultaneous accel+brake press cancels out.
  always_comb begin
    level_d = level_q;
    if (running) begin
      if (accel_press && !brake_press && level_q != LEVELWIDTH'(MAX_LEVEL))
        level_d = level_q + LEVELWIDTH'(1);
      else if (brake_press && !accel_press && level_q != '0)
        level_d = level_q - LEVELWIDTH'(1);
    end
  end

  // Outputs decoded from the next state so they line up with it once registered.
  always_comb begin
    upcount_d = (state_d != ST_RUN);
    tick_d    = (state_d == ST_WRAP);
    clear_d   = (state_d == ST_WRAP);
  end

  // State, level and output registers.
  always_ff @(posedge gclk) begin
    if (!grst_n) begin
      state_q   <= ST_IDLE;
      level_q   <= '0;
      upcount_q <= 1'b1;
      tick_q    <= 1'b0;
      clear_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      upcount_q <= upcount_d;
      tick_q    <= tick_d;
      clear_q   <= clear_d;
    end
  end

  assign SC_SPEEDTICK_upcount_OutLow = upcount_q;
  assign SC_SPEEDTICK_tick_OutHigh   = tick_q;
  assign SC_SPEEDTICK_clear_OutHigh  = clear_q;
  assign SC_SPEEDTICK_level_OutBUS   = level_q;

endmodule

// File: tb/tb_sc_speed_tick_gen.sv
// Bench for sc_speed_tick_gen with BASE_THRESH=64; the up-counter is modelled
// here and a behavioural reference predicts every output every cycle.
module tb_sc_speed_tick_gen;

  logic        clk = 1'b0;
  logic        rst_n, start_n, pause, accel_n, brake_n;
  logic [22:0] count;
  logic        upcount, clear, tick;
  logic [2:0]  level;

  int cnt;
  int nassert = 0;
  int nfail   = 0;
  int cyc = 0, last_tick = -1, period = -1, ntick = 0;
  // reference model: mode 0=idle 1=counting 2=wrap-pulse 3=paused
  int m_mode = 0, m_lvl = 0;
  bit m_pa = 1'b1, m_pb = 1'b1;

  assign count = 23'(cnt);

  always #5 clk = ~clk;

  sc_speed_tick_gen #(
    .DATAWIDTH(23), .LEVELWIDTH(3), .MAX_LEVEL(7), .BASE_THRESH(64)
  ) dut (
    .SC_SPEEDTICK_CLOCK_50       (clk),
    .SC_SPEEDTICK_RESET_InLow    (rst_n),
    .SC_SPEEDTICK_count_InBUS    (count),
    .SC_SPEEDTICK_start_InLow    (start_n),
    .SC_SPEEDTICK_pause_InHigh   (pause),
    .SC_SPEEDTICK_accel_InLow    (accel_n),
    .SC_SPEEDTICK_brake_InLow    (brake_n),
    .SC_SPEEDTICK_upcount_OutLow (upcount),
    .SC_SPEEDTICK_clear_OutHigh  (clear),
    .SC_SPEEDTICK_tick_OutHigh   (tick),
    .SC_SPEEDTICK_level_OutBUS   (level)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: predict, advance, then compare all outputs against the model.
  task automatic step();
    int thr, nmode, nlvl, ncnt;
    bit ap, bp, npa, npb;
    if (!rst_n) begin
      nmode = 0; nlvl = 0; npa = 1'b1; npb = 1'b1; ncnt = 0;
    end else begin
      thr = 64 >> m_lvl;
      if (thr == 0) thr = 1;
      ap = m_pa && !accel_n;
      bp = m_pb && !brake_n;
      case (m_mode)
        0:       nmode = start_n ? 0 : 1;
        1:       nmode = pause ? 3 : ((cnt >= thr) ? 2 : 1);
        default: nmode = pause ? 3 : 1;
      endcase
      nlvl = m_lvl;
      if ((m_mode == 1 || m_mode == 2) && ap != bp)
        nlvl = ap ? ((m_lvl < 7) ? m_lvl + 1 : 7) : ((m_lvl > 0) ? m_lvl - 1 : 0);
      npa = accel_n;
      npb = brake_n;
      ncnt = clear ? 0 : (!upcount ? cnt + 1 : cnt);
    end
    @(posedge clk);
    #1;
    m_mode = nmode; m_lvl = nlvl; m_pa = npa; m_pb = npb; cnt = ncnt;
    cyc++;
    if (tick) begin
      if (last_tick >= 0) period = cyc - last_tick;
      last_tick = cyc;
      ntick++;
    end
    chk("upcount", int'(upcount), (m_mode == 1) ? 0 : 1);
    chk("tick",    int'(tick),    (m_mode == 2) ? 1 : 0);
    chk("clear",   int'(clear),   (m_mode == 2) ? 1 : 0);
    chk("level",   int'(level),   m_lvl);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic press_a();
    accel_n = 1'b0; step();
    accel_n = 1'b1; step();
  endtask

  task automatic press_b();
    brake_n = 1'b0; step();
    brake_n = 1'b1; step();
  endtask

  task automatic wait_cnt(input int target);
    int k = 0;
    while (cnt != target && k < 500) begin step(); k++; end
    chk("wait_cnt", cnt, target);
  endtask

  task automatic wait_tick(output int k);
    k = 0;
    do begin step(); k++; end while (!tick && k < 500);
    chk("wait_tick", int'(tick), 1);
  endtask

  initial begin
    int k, c0, n0;
    rst_n = 1'b0; start_n = 1'b1; pause = 1'b0; accel_n = 1'b1; brake_n = 1'b1;
    cnt = 0;

    // reset state
    step(); step();
    chk("rst_upcount", int'(upcount), 1);
    chk("rst_tick", int'(tick), 0);
    chk("rst_clear", int'(clear), 0);
    chk("rst_level", int'(level), 0);
    rst_n = 1'b1; step();
    chk("idle_upcount", int'(upcount), 1);

    // start, first tick at count 64 (65 edges after start), then period 66
    start_n = 1'b0; step();
    chk("start_upcount", int'(upcount), 0);
    wait_tick(k);
    chk("first_tick_lat", k, 65);
    chk("first_tick_clear", int'(clear), 1);
    run(200);
    chk("period_l0", period, 66);

    // acceleration: level 3 -> period 10; saturate at 7 -> period 3
    repeat (3) press_a();
    chk("level_3", int'(level), 3);
    run(40);
    chk("period_l3", period, 10);
    repeat (8) press_a();
    chk("level_sat7", int'(level), 7);
    run(20);
    chk("period_l7", period, 3);

    // level-up below the current count: one tick right away, then period 34
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    wait_cnt(40);
    accel_n = 1'b0; step();
    chk("level_1", int'(level), 1);
    accel_n = 1'b1; step();
    chk("early_tick", int'(tick), 1);
    run(100);
    chk("period_l1", period, 34);

    // pause at count 20 for 50 cycles, resume from held value
    press_b();
    chk("level_back0", int'(level), 0);
    wait_cnt(20);
    pause = 1'b1;
    n0 = ntick;
    run(50);
    chk("pause_upcount", int'(upcount), 1);
    chk("pause_noticks", ntick - n0, 0);
    pause = 1'b0;
    wait_tick(k);
    chk("resume_lat", k, 45);

    // press rules: brake at 0, simultaneous, in PAUSE, in IDLE
    press_b();
    chk("brake_floor", int'(level), 0);
    press_a();
    chk("accel_to1", int'(level), 1);
    accel_n = 1'b0; brake_n = 1'b0; step();
    accel_n = 1'b1; brake_n = 1'b1; step();
    chk("simul_press", int'(level), 1);
    pause = 1'b1; step(); step();
    press_a();
    chk("press_in_pause", int'(level), 1);
    pause = 1'b0; step();
    rst_n = 1'b0; start_n = 1'b1; step(); rst_n = 1'b1; step();
    press_a();
    chk("press_in_idle", int'(level), 0);
    chk("idle_upcount2", int'(upcount), 1);

    // reset during the WRAP cycle cuts the pulse
    start_n = 1'b0; step();
    press_a(); press_a();
    chk("level_2", int'(level), 2);
    wait_tick(k);
    rst_n = 1'b0; step();
    chk("wrap_rst_tick", int'(tick), 0);
    chk("wrap_rst_clear", int'(clear), 0);
    chk("wrap_rst_upcount", int'(upcount), 1);
    chk("wrap_rst_level", int'(level), 0);
    rst_n = 1'b1;

    // randomized traffic against the reference model
    c0 = cyc;
    repeat (3000) begin
      rst_n   = ($urandom_range(0, 299) != 0);
      start_n = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 39) == 0) pause = ~pause;
      accel_n = ($urandom_range(0, 7) != 0);
      brake_n = ($urandom_range(0, 9) != 0);
      step();
    end
    chk("random_cycles", cyc - c0, 3000);

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
